// File: rtl/nanov_spi_fetch.sv
// nanoV instruction fetch: SPI NOR sequential read into a one-word valid/ready buffer.
// Define NANOV_SPI_FAST_READ_EN for fast read (0x0B) with 8 dummy bit slots.
module nanov_spi_fetch #(
    parameter int ADDR_BITS = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] start_addr,
    input  logic                 jump,
    input  logic [ADDR_BITS-1:0] jump_addr,
    output logic [31:0]          instr,
    output logic [ADDR_BITS-1:0] instr_pc,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    output logic                 spi_cs_n,
    output logic                 spi_sck,
    output logic                 spi_mosi,
    input  logic                 spi_miso
);
    localparam int HDR = 8 + ADDR_BITS;
    localparam logic [5:0] ADDR_LAST = 6'(ADDR_BITS - 1);
    localparam logic [ADDR_BITS-1:0] ALIGN = {{(ADDR_BITS-2){1'b1}}, 2'b00};
`ifdef NANOV_SPI_FAST_READ_EN
    localparam logic [7:0] READ_CMD = 8'h0B;
`else
    localparam logic [7:0] READ_CMD = 8'h03;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
`ifdef NANOV_SPI_FAST_READ_EN
        S_DUMMY,
`endif
        S_DATA,
        S_GAP
    } state_t;

    state_t               state_q, state_d;
    logic [5:0]           cnt_q;
    logic [HDR-1:0]       tx_q;
    logic [31:0]          rx_q;
    logic [ADDR_BITS-1:0] fa_q;
    logic                 pend_q;

    logic [ADDR_BITS-1:0] tgt;
    logic [HDR-1:0]       hdr;
    logic [31:0]          rx_next;
    logic                 restart, go_now, gap_done, launch;
    logic                 active, bit_end, last_bit, word_end;
    logic                 load_fresh, load_pend, load;

    function automatic logic [31:0] swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    assign tgt      = (start ? start_addr : jump_addr) & ALIGN;
    assign restart  = start || jump;
    assign go_now   = start && (state_q == S_IDLE);
    assign gap_done = (state_q == S_GAP) && (cnt_q == 6'd1);
    assign launch   = go_now || (gap_done && !restart);
    assign hdr      = {READ_CMD, go_now ? tgt : fa_q};
    assign active   = (state_q != S_IDLE) && (state_q != S_GAP);
    assign bit_end  = active && spi_sck;
    assign rx_next  = {rx_q[30:0], spi_miso};
    assign word_end = bit_end && (state_q == S_DATA) && last_bit;

    // Bytes arrive b0 first, so the shifted word is byte-reversed on load.
    assign load_fresh = word_end && (!instr_valid || instr_ready);
    assign load_pend  = active && !spi_sck && pend_q && instr_ready;
    assign load       = load_fresh || load_pend;

    always_comb begin
        last_bit = 1'b0;
        unique case (state_q)
            S_CMD:   last_bit = (cnt_q == 6'd7);
            S_ADDR:  last_bit = (cnt_q == ADDR_LAST);
`ifdef NANOV_SPI_FAST_READ_EN
            S_DUMMY: last_bit = (cnt_q == 6'd7);
`endif
            S_DATA:  last_bit = (cnt_q == 6'd31);
            default: last_bit = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        if (go_now) begin
            state_d = S_CMD;
        end else if (restart) begin
            state_d = S_GAP;
        end else if (gap_done) begin
            state_d = S_CMD;
        end else if (bit_end && last_bit) begin
            unique case (state_q)
                S_CMD:   state_d = S_ADDR;
`ifdef NANOV_SPI_FAST_READ_EN
                S_ADDR:  state_d = S_DUMMY;
                S_DUMMY: state_d = S_DATA;
`else
                S_ADDR:  state_d = S_DATA;
`endif
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            spi_cs_n    <= 1'b1;
            spi_sck     <= 1'b0;
            spi_mosi    <= 1'b0;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
            cnt_q       <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            fa_q        <= '0;
            pend_q      <= 1'b0;
        end else if (launch) begin
            // The launch edge opens the first high phase directly.
            spi_cs_n <= 1'b0;
            spi_sck  <= 1'b1;
            spi_mosi <= hdr[HDR-1];
            tx_q     <= hdr << 1;
            cnt_q    <= '0;
            if (go_now) fa_q <= tgt;
        end else if (restart) begin
            spi_cs_n    <= 1'b1;
            spi_sck     <= 1'b0;
            spi_mosi    <= 1'b0;
            instr_valid <= 1'b0;
            pend_q      <= 1'b0;
            cnt_q       <= '0;
            fa_q        <= tgt;
        end else if (state_q == S_GAP) begin
            cnt_q <= cnt_q + 6'd1;
        end else if (active) begin
            if (instr_valid && instr_ready) instr_valid <= 1'b0;
            if (load) begin
                instr       <= swap(load_fresh ? rx_next : rx_q);
                instr_pc    <= fa_q;
                instr_valid <= 1'b1;
                fa_q        <= fa_q + ADDR_BITS'(4);
            end
            if (spi_sck) begin
                spi_sck <= 1'b0;
                cnt_q   <= last_bit ? 6'd0 : cnt_q + 6'd1;
                if (state_q == S_CMD || state_q == S_ADDR) begin
                    tx_q     <= tx_q << 1;
                    spi_mosi <= (state_q == S_ADDR && last_bit) ? 1'b0 : tx_q[HDR-1];
                end
                if (state_q == S_DATA) begin
                    rx_q <= rx_next;
                    if (word_end && !load_fresh) pend_q <= 1'b1;
                end
            end else if (!pend_q) begin
                spi_sck <= 1'b1;
            end else if (instr_ready) begin
                pend_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_nanov_spi_fetch.sv
// Bench for nanov_spi_fetch: bit-level SPI flash model plus word scoreboard.
// Honours NANOV_SPI_FAST_READ_EN for command byte and latency.
module tb_nanov_spi_fetch;
    localparam int AB = 24;
`ifdef NANOV_SPI_FAST_READ_EN
    localparam logic [7:0] CMD = 8'h0B;
    localparam int DUMMY = 8;
`else
    localparam logic [7:0] CMD = 8'h03;
    localparam int DUMMY = 0;
`endif
    localparam int HDR = 8 + AB;
    localparam int LAT = 2 * (HDR + DUMMY + 32) - 1;

    logic          clk = 1'b0;
    logic          rst, start, jump, instr_ready, spi_miso;
    logic [AB-1:0] start_addr, jump_addr, instr_pc;
    logic [31:0]   instr;
    logic          instr_valid, spi_cs_n, spi_sck, spi_mosi;

    always #5 clk = ~clk;

    nanov_spi_fetch #(.ADDR_BITS(AB)) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
        .jump(jump), .jump_addr(jump_addr), .instr(instr),
        .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .spi_cs_n(spi_cs_n),
        .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    int     n_cmp = 0;
    int     n_fail = 0;
    longint cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] fb(input logic [AB-1:0] a);
        case (a)
            24'h000100: return 8'h13;
            24'h000101: return 8'h05;
            24'h000102: return 8'h00;
            24'h000103: return 8'h00;
            default:    return (a[7:0] * 8'd29) ^ a[15:8] ^ (a[23:16] * 8'd7) ^ 8'hA5;
        endcase
    endfunction

    function automatic logic [31:0] word_at(input logic [AB-1:0] pc);
        return {fb(pc + AB'(3)), fb(pc + AB'(2)), fb(pc + AB'(1)), fb(pc)};
    endfunction

    // Flash model, scoreboard and per-cycle idle checks, all on the falling edge.
    int            fn = 0;
    int            fd;
    int            n_words = 0;
    int            cs_hi = 0;
    logic [HDR-1:0] fhdr = '0;
    logic [7:0]    fbyte;
    logic [AB-1:0] fa = '0;
    logic [AB-1:0] exp_pc = '0;

    always @(negedge clk) begin
        if (spi_cs_n) begin
            fn = 0;
            spi_miso = 1'b0;
        end else if (spi_sck) begin
            if (fn < HDR) begin
                fhdr = {fhdr[HDR-2:0], spi_mosi};
                if (fn == HDR - 1) chk("flash_header", 64'(fhdr), 64'({CMD, fa}));
            end else if (fn >= HDR + DUMMY) begin
                fd = fn - HDR - DUMMY;
                fbyte = fb(fhdr[AB-1:0] + AB'(fd / 8));
                spi_miso = fbyte[7 - (fd % 8)];
            end
            fn++;
        end
        if (!rst && spi_cs_n) begin
            cs_hi++;
            chk("idle_sck", 64'(spi_sck), 64'd0);
            chk("idle_mosi", 64'(spi_mosi), 64'd0);
        end
        if (!rst && !start && !jump && instr_valid && instr_ready) begin
            chk("word_pc", 64'(instr_pc), 64'(exp_pc));
            chk("word_data", 64'(instr), 64'(word_at(exp_pc)));
            exp_pc = exp_pc + AB'(4);
            n_words++;
        end
        if (!rst && (start || jump)) begin
            fa = start ? start_addr : jump_addr;
            fa[1:0] = 2'b00;
            exp_pc = fa;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input bit is_jump, input logic [AB-1:0] a, output longint t);
        if (is_jump) begin
            jump = 1'b1;
            jump_addr = a;
        end else begin
            start = 1'b1;
            start_addr = a;
        end
        tick();
        t = cyc;
        start = 1'b0;
        jump = 1'b0;
    endtask

    task automatic wait_valid(input string nm, input int budget, output longint t);
        t = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (instr_valid) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: no instr_valid within %0d cycles", nm, budget);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        longint t0, tp, tv, tj;
        int     w0, cs0, sck_hi;
        logic [AB-1:0] ra;
        rst = 1'b1; start = 1'b0; jump = 1'b0;
        start_addr = '0; jump_addr = '0; instr_ready = 1'b0;
        repeat (3) tick();
        chk("rst_cs_n", 64'(spi_cs_n), 64'd1);
        chk("rst_sck", 64'(spi_sck), 64'd0);
        chk("rst_mosi", 64'(spi_mosi), 64'd0);
        chk("rst_valid", 64'(instr_valid), 64'd0);
        chk("rst_instr", 64'(instr), 64'd0);
        chk("rst_pc", 64'(instr_pc), 64'd0);
        rst = 1'b0;
        tick();

        // First word and streaming with ready held high
        instr_ready = 1'b1;
        pulse(1'b0, 24'h000103, t0);
        chk("cs_low_at_start", 64'(spi_cs_n), 64'd0);
        cs0 = cs_hi;
        wait_valid("first_word", LAT + 10, tv);
        chk("first_latency", 64'(tv - t0), 64'(LAT));
        chk("first_instr", 64'(instr), 64'h00000513);
        chk("first_pc", 64'(instr_pc), 64'h000100);
        for (int k = 1; k < 4; k++) begin
            tp = tv;
            tick();
            chk("valid_one_cycle", 64'(instr_valid), 64'd0);
            wait_valid("stream_word", 80, tv);
            chk("stream_spacing", 64'(tv - tp), 64'd64);
            chk("stream_pc", 64'(instr_pc), 64'(24'h000100 + 4 * k));
        end
        tick();
        chk("no_cs_deassert", 64'(cs_hi - cs0), 64'd0);

        // Stall with the buffer full
        instr_ready = 1'b0;
        sck_hi = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (i >= 140 && spi_sck) sck_hi++;
        end
        chk("stall_sck_quiet", 64'(sck_hi), 64'd0);
        chk("stall_cs_low", 64'(spi_cs_n), 64'd0);
        chk("stall_valid", 64'(instr_valid), 64'd1);
        chk("stall_pc", 64'(instr_pc), 64'h000110);
        instr_ready = 1'b1;
        tick();
        chk("release_pc", 64'(instr_pc), 64'h000114);
        chk("release_valid", 64'(instr_valid), 64'd1);
        tick();
        chk("sck_resumes", 64'(spi_sck), 64'd1);

        // Jump mid-word while a word is held
        instr_ready = 1'b0;
        wait_valid("pre_jump", 100, tv);
        repeat (10) tick();
        chk("valid_before_jump", 64'(instr_valid), 64'd1);
        instr_ready = 1'b1;
        pulse(1'b1, 24'h000201, tj);
        chk("jump_clears_valid", 64'(instr_valid), 64'd0);
        chk("jump_cs_high0", 64'(spi_cs_n), 64'd1);
        chk("jump_sck_low", 64'(spi_sck), 64'd0);
        tick();
        chk("jump_cs_high1", 64'(spi_cs_n), 64'd1);
        tick();
        chk("jump_cs_low", 64'(spi_cs_n), 64'd0);
        wait_valid("jump_word", LAT + 10, tv);
        chk("jump_latency", 64'(tv - tj), 64'(LAT + 2));
        chk("jump_pc", 64'(instr_pc), 64'h000200);

        // Start while busy acts as a jump; address wraps at the top
        pulse(1'b0, 24'hFFFFFE, tj);
        wait_valid("wrap_first", LAT + 12, tv);
        chk("start_as_jump_latency", 64'(tv - tj), 64'(LAT + 2));
        chk("wrap_first_pc", 64'(instr_pc), 64'hFFFFFC);
        wait_valid("wrap_next", 80, tv);
        chk("wrap_next_pc", 64'(instr_pc), 64'h000000);
        chk("wrap_next_data", 64'(instr), 64'hF29FB8A5);

        // Random ready and random jumps against the model
        w0 = n_words;
        for (int i = 0; i < 6000; i++) begin
            instr_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 399) == 0) begin
                ra = AB'($urandom);
                if ($urandom_range(0, 1) == 1) ra[AB-1:6] = '1;
                pulse(1'b1, ra, tj);
            end else begin
                tick();
            end
        end
        chk("random_progress", 64'(n_words - w0 > 20), 64'd1);

        // Reset with a word held, then reset mid-ADDR
        instr_ready = 1'b0;
        wait_valid("pre_rst", 400, tv);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_clears_valid", 64'(instr_valid), 64'd0);
        chk("rst_cs_high", 64'(spi_cs_n), 64'd1);
        instr_ready = 1'b1;
        pulse(1'b0, 24'h000300, t0);
        repeat (20) tick();
        chk("mid_addr_cs_low", 64'(spi_cs_n), 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_addr_rst_cs", 64'(spi_cs_n), 64'd1);
        chk("mid_addr_rst_sck", 64'(spi_sck), 64'd0);
        chk("mid_addr_rst_mosi", 64'(spi_mosi), 64'd0);
        chk("mid_addr_rst_valid", 64'(instr_valid), 64'd0);
        tick();
        pulse(1'b0, 24'h000304, t0);
        wait_valid("after_rst_word", LAT + 10, tv);
        chk("after_rst_latency", 64'(tv - t0), 64'(LAT));
        chk("after_rst_pc", 64'(instr_pc), 64'h000304);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
